// File: rtl/mem_source_streamer_pkg.sv
// Shared definitions for the memory source streamer.
// Provides the FSM state encoding and the default address/data widths
// used by the interface, the skid buffer and the top level.
package src_pkg;

  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_DATA_WIDTH = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    STREAM = ST_STREAM,
    DRAIN  = ST_DRAIN,
    DONE   = ST_DONE
  } state_e;

endpackage

// File: rtl/mem_source_streamer_if.sv
// Bundle of the streamer's control, memory-read and FIFO-write signals.
// master : the streamer (drives rd_addr_o, rd_en_o, fifo_wdata_o,
//          fifo_wen_o, busy_o, done_o; receives start_i, nop_i, full_i,
//          ilen_i, rd_data_i)
// slave  : the surrounding environment (opposite directions)
interface mem_source_streamer_if
  import src_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  start_i;
  logic                  nop_i;
  logic                  full_i;
  logic [ADDR_WIDTH-1:0] ilen_i;
  logic [ADDR_WIDTH-1:0] rd_addr_o;
  logic                  rd_en_o;
  logic [DATA_WIDTH-1:0] rd_data_i;
  logic [DATA_WIDTH-1:0] fifo_wdata_o;
  logic                  fifo_wen_o;
  logic                  busy_o;
  logic                  done_o;

  modport master (
    input  start_i, nop_i, full_i, ilen_i, rd_data_i,
    output rd_addr_o, rd_en_o, fifo_wdata_o, fifo_wen_o, busy_o, done_o
  );

  modport slave (
    output start_i, nop_i, full_i, ilen_i, rd_data_i,
    input  rd_addr_o, rd_en_o, fifo_wdata_o, fifo_wen_o, busy_o, done_o
  );

endinterface

// File: rtl/mem_source_streamer_skid.sv
// skid_fifo2: two-entry FIFO that catches memory read data arriving one
// cycle after the read strobe.
// Ports: clk, rstn (async active-low), push/din (write side),
//        pop (read side), count (occupancy 0..2), head (oldest entry).
// Push and pop in the same cycle are allowed; the caller never pushes
// into a full buffer nor pops an empty one.
module skid_fifo2
  import src_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] slot [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            cnt;

  // Data slots are cleared on reset so the FIFO write data output reads 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot[0] <= '0;
      slot[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      cnt     <= 2'd0;
    end else begin
      if (push) begin
        slot[wr_ptr] <= din;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign count = cnt;
  assign head  = slot[rd_ptr];

endmodule

// File: rtl/mem_source_streamer.sv
// mem_source_streamer: reads ilen_i words from a synchronous-read sample
// memory (addresses 0..ilen_i-1) and pushes them in order into the
// interpolator input FIFO.
// Ports: clk, rstn (async active-low), bus (master modport) carrying
//        start_i/nop_i/full_i/ilen_i control, the memory read port
//        (rd_addr_o, rd_en_o, rd_data_i), the FIFO write port
//        (fifo_wdata_o, fifo_wen_o) and status (busy_o, done_o).
module mem_source_streamer
  import src_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rstn,
  mem_source_streamer_if.master bus
);

  state_e                state_q, state_n;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic                  inflight;
  logic                  rd_en;
  logic                  pop;
  logic [1:0]            skid_count;
  logic [DATA_WIDTH-1:0] skid_head;
  logic [2:0]            occ;

  skid_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk   (clk),
    .rstn  (rstn),
    .push  (inflight),
    .pop   (pop),
    .din   (bus.rd_data_i),
    .count (skid_count),
    .head  (skid_head)
  );

  assign pop = (skid_count != 2'd0) && !bus.full_i;

  // Words that will still be held after this cycle's pop. A new read is
  // only issued when at most one remains, so buffered plus in-flight
  // never exceeds the two skid slots.
  assign occ = {1'b0, skid_count} + {2'b00, inflight} - {2'b00, pop};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) state_n = STREAM;
      end
      STREAM: begin
        rd_en = !bus.nop_i && (rd_cnt < len_q) && (occ <= 3'd1);
        if (rd_cnt == len_q) state_n = DRAIN;
      end
      DRAIN: begin
        if ((skid_count == 2'd0) && !inflight) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q    <= '0;
      rd_cnt   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_en;
      if ((state_q == IDLE) && bus.start_i) begin
        len_q  <= bus.ilen_i;
        rd_cnt <= '0;
      end else if (rd_en) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  assign bus.rd_en_o      = rd_en;
  assign bus.rd_addr_o    = rd_cnt;
  assign bus.fifo_wen_o   = pop;
  assign bus.fifo_wdata_o = skid_head;
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.done_o       = (state_q == DONE);

endmodule

// File: tb/tb_mem_source_streamer.sv
// Testbench for mem_source_streamer: models the sample memory, records
// reads/writes/done pulses each cycle, and compares them with the
// sequence a transfer of len words must produce.
module tb_mem_source_streamer;
  localparam int AW = 7;
  localparam int DW = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_source_streamer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_source_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] mem [1<<AW];

  logic [DW-1:0] wr_q [$];
  int wr_cyc_q [$];
  int rd_addr_q [$];
  int rd_cyc_q [$];
  int done_n, done_cyc, busy_n, full_viol, nop_viol, occ_viol;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read sample memory
  always @(posedge clk)
    if (bus.rd_en_o) bus.rd_data_i <= mem[bus.rd_addr_o];

  // observation, mid-cycle
  always @(negedge clk) begin
    if (bus.rd_en_o) begin
      rd_addr_q.push_back(int'(bus.rd_addr_o));
      rd_cyc_q.push_back(cyc);
      if (bus.nop_i) nop_viol++;
    end
    if (bus.fifo_wen_o) begin
      wr_q.push_back(bus.fifo_wdata_o);
      wr_cyc_q.push_back(cyc);
      if (bus.full_i) full_viol++;
    end
    if (bus.done_o) begin
      done_n++;
      done_cyc = cyc;
    end
    if (bus.busy_o) busy_n++;
    if (rd_addr_q.size() - wr_q.size() > 2) occ_viol++;
  end

  task automatic clear_mon();
    wr_q.delete(); wr_cyc_q.delete(); rd_addr_q.delete(); rd_cyc_q.delete();
    done_n = 0; done_cyc = -1; busy_n = 0;
    full_viol = 0; nop_viol = 0; occ_viol = 0;
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'hA0 + i;
  endtask

  task automatic fill_random();
    for (int i = 0; i < (1<<AW); i++) mem[i] = $urandom;
  endtask

  // called just after a rising edge; returns the cycle start_i was high
  task automatic do_start(input int len, output int s);
    logic [31:0] lv;
    lv = len;
    bus.start_i = 1'b1;
    bus.ilen_i  = lv[AW-1:0];
    s = cyc;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.ilen_i  = AW'($urandom);
  endtask

  task automatic wait_idle(input int budget, output bit timeout);
    int n = 0;
    while (bus.busy_o && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    timeout = bus.busy_o;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.rd_en_o !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", bus.rd_en_o); end
    total++; if (bus.rd_addr_o !== '0) begin bad++; $display("FAIL reset_rd_addr got=%0d want=0", bus.rd_addr_o); end
    total++; if (bus.fifo_wen_o !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b want=0", bus.fifo_wen_o); end
    total++; if (bus.fifo_wdata_o !== '0) begin bad++; $display("FAIL reset_wdata got=%h want=0", bus.fifo_wdata_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy_o); end
    total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done_o); end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int s; bit to;
    fill_pattern(); clear_mon();
    do_start(8, s);
    wait_idle(100, to);
    total++; if (to) begin bad++; $display("FAIL basic_timeout busy got=1 want=0"); end
    total++; if (rd_addr_q.size() != 8) begin bad++; $display("FAIL basic_reads got=%0d want=8", rd_addr_q.size()); end
    total++; if (wr_q.size() != 8) begin bad++; $display("FAIL basic_writes got=%0d want=8", wr_q.size()); end
    if (rd_cyc_q.size() > 0) begin
      total++; if (rd_cyc_q[0] != s + 1) begin bad++; $display("FAIL basic_first_read cyc got=%0d want=%0d", rd_cyc_q[0], s + 1); end
      for (int i = 0; i < rd_addr_q.size() && i < 8; i++) begin
        total++;
        if (rd_addr_q[i] != i || rd_cyc_q[i] != rd_cyc_q[0] + i) begin
          bad++; $display("FAIL basic_read[%0d] addr/cyc got=%0d/%0d want=%0d/%0d", i, rd_addr_q[i], rd_cyc_q[i], i, rd_cyc_q[0] + i);
        end
      end
      for (int i = 0; i < wr_q.size() && i < 8; i++) begin
        total++;
        if (wr_q[i] !== 32'hA0 + i || wr_cyc_q[i] != rd_cyc_q[0] + 2 + i) begin
          bad++; $display("FAIL basic_write[%0d] data/cyc got=%h/%0d want=%h/%0d", i, wr_q[i], wr_cyc_q[i], 32'hA0 + i, rd_cyc_q[0] + 2 + i);
        end
      end
    end
    total++; if (done_n != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", done_n); end
  endtask

  task automatic test_full_stall();
    int s, n, fst, k, e; bit to;
    fill_pattern(); clear_mon();
    do_start(6, s);
    n = 0; fst = 0; k = 0; e = -1;
    while (bus.busy_o && n < 200) begin
      if (fst == 0 && wr_q.size() >= 2) begin
        bus.full_i = 1'b1; fst = 1; k = 0;
      end else if (fst == 1) begin
        k++;
        if (k == 5) begin bus.full_i = 1'b0; fst = 2; e = cyc; end
      end
      @(posedge clk); #1;
      n++;
    end
    bus.full_i = 1'b0;
    to = bus.busy_o;
    total++; if (to) begin bad++; $display("FAIL full_timeout busy got=1 want=0"); end
    total++; if (wr_q.size() != 6) begin bad++; $display("FAIL full_writes got=%0d want=6", wr_q.size()); end
    for (int i = 0; i < wr_q.size() && i < 6; i++) begin
      total++; if (wr_q[i] !== 32'hA0 + i) begin bad++; $display("FAIL full_data[%0d] got=%h want=%h", i, wr_q[i], 32'hA0 + i); end
    end
    if (wr_cyc_q.size() > 2) begin
      total++; if (wr_cyc_q[2] != e) begin bad++; $display("FAIL full_resume cyc got=%0d want=%0d", wr_cyc_q[2], e); end
    end
    total++; if (full_viol != 0) begin bad++; $display("FAIL full_write_while_full got=%0d want=0", full_viol); end
    total++; if (occ_viol != 0) begin bad++; $display("FAIL full_held_over_2 got=%0d want=0", occ_viol); end
    total++; if (done_n != 1) begin bad++; $display("FAIL full_done_pulses got=%0d want=1", done_n); end
  endtask

  task automatic test_nop_stall();
    int s, n, fst, k, n0; bit to;
    fill_pattern(); clear_mon();
    do_start(5, s);
    n = 0; fst = 0; k = 0; n0 = -1;
    while (bus.busy_o && n < 200) begin
      if (fst == 0 && rd_addr_q.size() >= 2) begin
        bus.nop_i = 1'b1; fst = 1; k = 0; n0 = cyc;
      end else if (fst == 1) begin
        k++;
        if (k == 3) begin bus.nop_i = 1'b0; fst = 2; end
      end
      @(posedge clk); #1;
      n++;
    end
    bus.nop_i = 1'b0;
    to = bus.busy_o;
    total++; if (to) begin bad++; $display("FAIL nop_timeout busy got=1 want=0"); end
    total++; if (rd_addr_q.size() != 5) begin bad++; $display("FAIL nop_reads got=%0d want=5", rd_addr_q.size()); end
    total++; if (nop_viol != 0) begin bad++; $display("FAIL nop_read_during_nop got=%0d want=0", nop_viol); end
    if (rd_cyc_q.size() > 2) begin
      total++; if (rd_cyc_q[2] != n0 + 3) begin bad++; $display("FAIL nop_resume cyc got=%0d want=%0d", rd_cyc_q[2], n0 + 3); end
    end
    total++; if (wr_q.size() != 5) begin bad++; $display("FAIL nop_writes got=%0d want=5", wr_q.size()); end
    for (int i = 0; i < wr_q.size() && i < 5; i++) begin
      total++; if (wr_q[i] !== 32'hA0 + i) begin bad++; $display("FAIL nop_data[%0d] got=%h want=%h", i, wr_q[i], 32'hA0 + i); end
    end
  endtask

  task automatic test_zero_len();
    int s; bit to;
    clear_mon();
    do_start(0, s);
    wait_idle(20, to);
    total++; if (to) begin bad++; $display("FAIL zero_timeout busy got=1 want=0"); end
    total++; if (rd_addr_q.size() != 0 || wr_q.size() != 0) begin bad++; $display("FAIL zero_traffic reads/writes got=%0d/%0d want=0/0", rd_addr_q.size(), wr_q.size()); end
    total++; if (done_n != 1 || done_cyc != s + 3) begin bad++; $display("FAIL zero_done n/cyc got=%0d/%0d want=1/%0d", done_n, done_cyc, s + 3); end
    total++; if (busy_n != 3) begin bad++; $display("FAIL zero_busy_cycles got=%0d want=3", busy_n); end
  endtask

  task automatic test_reset_mid();
    int s, n; bit to;
    fill_pattern(); clear_mon();
    do_start(8, s);
    n = 0;
    while (wr_q.size() < 3 && n < 100) begin @(posedge clk); #1; n++; end
    rstn = 1'b0;
    #1;
    total++;
    if (bus.rd_en_o !== 1'b0 || bus.fifo_wen_o !== 1'b0 || bus.busy_o !== 1'b0 ||
        bus.done_o !== 1'b0 || bus.rd_addr_o !== '0 || bus.fifo_wdata_o !== '0) begin
      bad++;
      $display("FAIL midreset_outputs rd_en/wen/busy/done/addr/wdata got=%b/%b/%b/%b/%0d/%h want=0/0/0/0/0/0",
               bus.rd_en_o, bus.fifo_wen_o, bus.busy_o, bus.done_o, bus.rd_addr_o, bus.fifo_wdata_o);
    end
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    do_start(4, s);
    wait_idle(100, to);
    total++; if (to) begin bad++; $display("FAIL restart_timeout busy got=1 want=0"); end
    total++; if (rd_addr_q.size() != 4 || wr_q.size() != 4) begin bad++; $display("FAIL restart_counts reads/writes got=%0d/%0d want=4/4", rd_addr_q.size(), wr_q.size()); end
    for (int i = 0; i < rd_addr_q.size() && i < 4; i++) begin
      total++; if (rd_addr_q[i] != i) begin bad++; $display("FAIL restart_addr[%0d] got=%0d want=%0d", i, rd_addr_q[i], i); end
    end
    for (int i = 0; i < wr_q.size() && i < 4; i++) begin
      total++; if (wr_q[i] !== 32'hA0 + i) begin bad++; $display("FAIL restart_data[%0d] got=%h want=%h", i, wr_q[i], 32'hA0 + i); end
    end
  endtask

  task automatic test_start_ignored();
    int s; bit to;
    fill_pattern(); clear_mon();
    do_start(6, s);
    repeat (2) @(posedge clk);
    #1;
    bus.start_i = 1'b1; bus.ilen_i = 7'd2;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    wait_idle(100, to);
    repeat (3) @(posedge clk);
    #1;
    total++; if (to || bus.busy_o !== 1'b0) begin bad++; $display("FAIL restart_ign_busy got=%b want=0", bus.busy_o); end
    total++; if (wr_q.size() != 6) begin bad++; $display("FAIL restart_ign_writes got=%0d want=6", wr_q.size()); end
    for (int i = 0; i < wr_q.size() && i < 6; i++) begin
      total++; if (wr_q[i] !== 32'hA0 + i) begin bad++; $display("FAIL restart_ign_data[%0d] got=%h want=%h", i, wr_q[i], 32'hA0 + i); end
    end
    total++; if (done_n != 1) begin bad++; $display("FAIL restart_ign_done got=%0d want=1", done_n); end
  endtask

  task automatic test_max_len();
    int s, errs; bit to;
    fill_pattern(); clear_mon();
    do_start((1<<AW) - 1, s);
    wait_idle(400, to);
    total++; if (to) begin bad++; $display("FAIL max_timeout busy got=1 want=0"); end
    total++; if (rd_addr_q.size() != (1<<AW) - 1) begin bad++; $display("FAIL max_reads got=%0d want=%0d", rd_addr_q.size(), (1<<AW) - 1); end
    if (rd_addr_q.size() > 0) begin
      total++; if (rd_addr_q[$] != (1<<AW) - 2) begin bad++; $display("FAIL max_last_addr got=%0d want=%0d", rd_addr_q[$], (1<<AW) - 2); end
    end
    errs = 0;
    for (int i = 0; i < wr_q.size(); i++)
      if (wr_q[i] !== 32'hA0 + i || wr_cyc_q[i] != wr_cyc_q[0] + i) errs++;
    total++; if (wr_q.size() != (1<<AW) - 1 || errs != 0) begin bad++; $display("FAIL max_writes n/errs got=%0d/%0d want=%0d/0", wr_q.size(), errs, (1<<AW) - 1); end
  endtask

  task automatic test_random();
    int s, n, len, errs; bit to;
    for (int it = 0; it < 4; it++) begin
      fill_random(); clear_mon();
      len = $urandom_range(1, 40);
      do_start(len, s);
      n = 0;
      while (bus.busy_o && n < 2000) begin
        bus.full_i = ($urandom_range(0, 3) == 0);
        bus.nop_i  = ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
        n++;
      end
      bus.full_i = 1'b0; bus.nop_i = 1'b0;
      to = bus.busy_o;
      errs = 0;
      for (int i = 0; i < wr_q.size() && i < len; i++) if (wr_q[i] !== mem[i]) errs++;
      for (int i = 0; i < rd_addr_q.size(); i++) if (rd_addr_q[i] != i) errs++;
      total++; if (to) begin bad++; $display("FAIL rand%0d_timeout busy got=1 want=0", it); end
      total++; if (wr_q.size() != len || rd_addr_q.size() != len) begin bad++; $display("FAIL rand%0d_counts writes/reads got=%0d/%0d want=%0d", it, wr_q.size(), rd_addr_q.size(), len); end
      total++; if (errs != 0) begin bad++; $display("FAIL rand%0d_order errs got=%0d want=0", it, errs); end
      total++; if (full_viol + nop_viol + occ_viol != 0) begin bad++; $display("FAIL rand%0d_rules full/nop/held got=%0d/%0d/%0d want=0/0/0", it, full_viol, nop_viol, occ_viol); end
      total++; if (done_n != 1) begin bad++; $display("FAIL rand%0d_done got=%0d want=1", it, done_n); end
    end
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.nop_i   = 1'b0;
    bus.full_i  = 1'b0;
    bus.ilen_i  = '0;
    bus.rd_data_i = '0;
    clear_mon();
    test_reset();
    test_basic();
    test_full_stall();
    test_nop_stall();
    test_zero_len();
    test_reset_mid();
    test_start_ignored();
    test_max_len();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_source_streamer.md
Name: mem_source_streamer

Overview:
Upstream feeder for the interpolator input FIFO. On start it reads ilen_i consecutive words from a synchronous-read sample memory at addresses 0..ilen_i-1 and pushes them, in order, into the input FIFO.
- Honours FIFO back-pressure (full_i) and a stall request (nop_i).
- A 2-entry skid buffer absorbs the 1-cycle memory read latency, so it streams at 1 word/cycle when unthrottled.
- Mirror of the downstream sink stage, which drains the output FIFO into memory.

Parameters:
ADDR_WIDTH, 7, width of memory address and length (covers 100 samples)
DATA_WIDTH, 32, sample word width

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous, active-low reset
start_i  in  1  start request, sampled only in IDLE
nop_i  in  1  stall: suppresses new memory reads while high
full_i  in  1  input FIFO full
ilen_i  in  ADDR_WIDTH  number of words to transfer, latched at start
rd_addr_o  out  ADDR_WIDTH  memory read address
rd_en_o  out  1  memory read strobe; data valid on rd_data_i next cycle
rd_data_i  in  DATA_WIDTH  memory read data (1-cycle latency)
fifo_wdata_o  out  DATA_WIDTH  FIFO write data
fifo_wen_o  out  1  FIFO write strobe
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle completion pulse

Behaviour:
Reset (async, any state, including mid-transfer):
- state=IDLE; rd_cnt=0, len_q=0, inflight=0; skid buffer emptied.
- All outputs 0; in-flight read data is discarded.

States: IDLE, STREAM, DRAIN, DONE (2-bit encoding).
- IDLE: start_i=1 -> len_q<=ilen_i, rd_cnt<=0, go to STREAM. Otherwise stay.
- STREAM: issue reads per the rule below. When rd_cnt==len_q (evaluated on the registered value), go to DRAIN. No read is issued in that cycle.
- DRAIN: no reads. When skid empty and inflight==0, go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- start_i outside IDLE is ignored. ilen_i changes after start have no effect.

Read issue (combinational, registered address):
- rd_en_o = STREAM & !nop_i & (rd_cnt<len_q) & (skid_count + inflight - pop <= 1).
- rd_addr_o = rd_cnt.
- rd_cnt increments on rd_en_o.
- inflight <= rd_en_o. rd_data_i is pushed into the skid buffer in the cycle after rd_en_o.

FIFO write:
- pop = (skid_count!=0) & !full_i.
- fifo_wen_o = pop; fifo_wdata_o = skid head (combinational from the skid register).
- Never write while full_i=1.

Boundaries:
- Skid buffer never overflows. Push and pop in the same cycle are both allowed.
- Steady state with full_i=0 and nop_i=0: one word per cycle.
- First FIFO write occurs 2 cycles after the first rd_en_o.
- nop_i only blocks issue. Buffered and in-flight words still drain.
- full_i high for N cycles: issue stops once 2 words are held. No data is lost or reordered.
- ilen_i=0: IDLE -> STREAM -> DRAIN -> DONE. No rd_en_o or fifo_wen_o. done_o 3 cycles after start.
- ilen_i=2^ADDR_WIDTH-1: rd_addr_o tops out at len-1, with no wrap.
- Total FIFO writes always equal len_q.

Decomposition:
- Package src_pkg: state encoding localparams (IDLE, STREAM, DRAIN, DONE) and the default ADDR_WIDTH/DATA_WIDTH.
- One sub-module, skid_fifo2: 2-entry, DATA_WIDTH-wide FIFO with push, pop, count[1:0], head data, and async active-low reset.
- Top level holds the FSM, rd_cnt, and the inflight flag.

Test Plan:
- ilen=8, mem[i]=0xA0+i, full_i=0, nop_i=0 -> rd_en_o high for 8 consecutive cycles (addr 0..7); fifo_wen_o high for 8 consecutive cycles with data 0xA0..0xA7; done_o pulses once; total 8 writes.
- ilen=6, full_i high for 5 cycles after the 2nd write -> at most 2 reads in flight or buffered during the stall; writes resume in order 0xA2..0xA5; no write while full_i=1.
- ilen=5, nop_i high for 3 cycles mid-stream -> rd_en_o low exactly during nop; words already in flight still written; full sequence 0xA0..0xA4 delivered.
- ilen=0 -> zero reads and zero writes; done_o asserted exactly 3 cycles after the start cycle; busy_o high for 3 cycles.
- rstn asserted mid-stream after 3 writes, then restart with ilen=4 -> outputs drop to 0 immediately; after restart, addresses begin at 0 and data 0xA0..0xA3 with no stale words.
- start_i re-pulsed during STREAM with a different ilen_i -> ignored; original length completes; single done_o.
